hpu_sll_rr_sched: RTL and testbench

- Round-robin scheduler that shares one qualified SLL crossing lane among N_REQ valid/ready requesters.
- The lane has no backpressure, so the block tracks downstream buffer space with a credit counter. Each credit is one free slot in the far-side receive FIFO.
- Supports multi-beat bursts delimited by last; a granted requester keeps the lane until its last beat.
- Sits on the source side of an SLL crossing pipe and drives its data/ctrl inputs directly.

---
 rtl/hpu_sll_rr_sched.sv | 124 ++++++++++++
 tb/tb_hpu_sll_rr_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hpu_sll_rr_sched.sv
// rtl/hpu_sll_rr_sched.sv - credit-gated round-robin scheduler feeding one SLL crossing lane
module hpu_sll_rr_sched #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CREDIT_MAX = 8,
    parameter int ID_W       = $clog2(N_REQ),
    parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        s_rst,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_vld,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_rdy,
    output logic [DATA_WIDTH-1:0]       sll_data,
    output logic                        sll_avail,
    output logic                        sll_last,
    output logic [ID_W-1:0]             sll_id,
    input  logic                        credit_ret,
    output logic [CREDIT_W-1:0]         credit_cnt,
    output logic                        credit_err
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, owner;
    logic [ID_W-1:0] winner, cand, grant_id;
    logic            found, grant_vld, can_send, accept, acc_last;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == N_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // Scan from the highest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (req_vld[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant_id  = (state == BURST) ? owner : winner;
    assign grant_vld = (state == BURST) ? req_vld[owner] : found;
    assign can_send  = (credit_cnt != '0);
    assign accept    = grant_vld & can_send;
    assign acc_last  = req_last[grant_id];

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !acc_last) state_nxt = BURST;
            BURST:   if (accept && acc_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            ptr   <= '0;
            owner <= '0;
        end else if (accept) begin
            if (acc_last) begin
                ptr <= next_id(grant_id);
            end else if (state == IDLE) begin
                owner <= grant_id;
            end
        end
    end

    // Lane register: qualifiers drop to zero on idle cycles, payload holds.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            sll_data  <= '0;
            sll_avail <= 1'b0;
            sll_last  <= 1'b0;
            sll_id    <= '0;
        end else begin
            sll_avail <= accept;
            sll_last  <= accept & acc_last;
            sll_id    <= accept ? grant_id : '0;
            if (accept) sll_data <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            credit_cnt <= CREDIT_W'(CREDIT_MAX);
            credit_err <= 1'b0;
        end else begin
            case ({accept, credit_ret})
                2'b10: credit_cnt <= credit_cnt - CREDIT_W'(1);
                2'b01: begin
                    if (credit_cnt == CREDIT_W'(CREDIT_MAX)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CREDIT_W'(1);
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_hpu_sll_rr_sched.sv
// tb/tb_hpu_sll_rr_sched.sv - table-driven bench for hpu_sll_rr_sched
module tb_hpu_sll_rr_sched;

    localparam int N_REQ      = 4;
    localparam int DATA_WIDTH = 32;
    localparam int CREDIT_MAX = 8;

    logic                        clk = 1'b0;
    logic                        s_rst = 1'b0;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_vld = '0;
    logic [N_REQ-1:0]            req_last = '0;
    logic [N_REQ-1:0]            req_rdy;
    logic [DATA_WIDTH-1:0]       sll_data;
    logic                        sll_avail;
    logic                        sll_last;
    logic [1:0]                  sll_id;
    logic                        credit_ret = 1'b0;
    logic [3:0]                  credit_cnt;
    logic                        credit_err;

    hpu_sll_rr_sched #(
        .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .CREDIT_MAX(CREDIT_MAX)
    ) dut (
        .clk(clk), .s_rst(s_rst), .req_data(req_data), .req_vld(req_vld),
        .req_last(req_last), .req_rdy(req_rdy), .sll_data(sll_data),
        .sll_avail(sll_avail), .sll_last(sll_last), .sll_id(sll_id),
        .credit_ret(credit_ret), .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] last;
        logic       ret;
        logic [3:0] rdy;
        logic       avail;
        logic [1:0] id;
        logic       slast;
        logic [3:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] base_data(input int i);
        return 32'hC0DE_0000 | (i << 8) | i;
    endfunction

    task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] last,
                       input logic ret, input logic [3:0] rdy, input logic avail,
                       input logic [1:0] id, input logic slast, input logic [3:0] cnt,
                       input logic err);
        vec_t v;
        v.rst = rst; v.vld = vld; v.last = last; v.ret = ret; v.rdy = rdy;
        v.avail = avail; v.id = id; v.slast = slast; v.cnt = cnt; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Inputs change after the falling edge; rdy sampled before the rising edge, lane after it.
    task automatic apply(input vec_t v);
        int idx;
        idx = vectors;
        vectors++;
        @(negedge clk);
        s_rst      = v.rst;
        req_vld    = v.vld;
        req_last   = v.last;
        credit_ret = v.ret;
        #1;
        if (!v.rst) check("req_rdy", idx, 32'(req_rdy), 32'(v.rdy));
        @(posedge clk);
        #1;
        check("sll_avail", idx, 32'(sll_avail), 32'(v.avail));
        check("sll_id", idx, 32'(sll_id), 32'(v.id));
        check("sll_last", idx, 32'(sll_last), 32'(v.slast));
        check("credit_cnt", idx, 32'(credit_cnt), 32'(v.cnt));
        check("credit_err", idx, 32'(credit_err), 32'(v.err));
        if (v.rst) check("sll_data_rst", idx, sll_data, 32'h0);
        else if (v.avail) check("sll_data", idx, sll_data, base_data(int'(v.id)));
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = base_data(i);

        // reset state
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);
        // rotation with credit_ret tied high
        add(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 8, 0);
        // burst lock: req 1 moves ptr to 2, req 2 sends 3 beats, then 3 and 0
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);
        add(0, 4'h2, 4'hF, 1, 4'h2, 1, 1, 1, 8, 0);
        add(0, 4'hF, 4'hB, 1, 4'h4, 1, 2, 0, 8, 0);
        add(0, 4'hF, 4'hB, 1, 4'h4, 1, 2, 0, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 8, 0);
        add(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 8, 0);
        // burst stall: req 1 owner drops vld for 5 cycles, req 0 locked out
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);
        add(0, 4'h2, 4'h0, 0, 4'h2, 1, 1, 0, 7, 0);
        add(0, 4'h3, 4'h0, 0, 4'h2, 1, 1, 0, 6, 0);
        for (int k = 0; k < 5; k++) add(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 6, 0);
        add(0, 4'h3, 4'h3, 0, 4'h2, 1, 1, 1, 5, 0);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 4, 0);
        // credit exhaustion and single-credit return latency
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);
        for (int k = 0; k < 8; k++) add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 4'(7 - k), 0);
        add(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'h1, 4'h1, 1, 4'h0, 0, 0, 0, 1, 0);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 0, 0);
        add(0, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 0, 0);
        // simultaneous accept+return, then overflow and sticky error
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 7, 0);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 6, 0);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 5, 0);
        add(0, 4'h1, 4'h1, 1, 4'h1, 1, 0, 1, 5, 0);
        add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 6, 0);
        add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 7, 0);
        add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 8, 0);
        add(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 8, 1);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1, 0, 1, 7, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 7, 1);
        add(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 8, 0);

        foreach (tbl[i]) apply(tbl[i]);

        // reset mid-burst: ptr parked at 3, req 3 burst cut off on beat 2
        begin
            vec_t v;
            v = '{rst:0, vld:4'h4, last:4'h4, ret:1, rdy:4'h4, avail:1, id:2, slast:1, cnt:8, err:0};
            apply(v);
            v = '{rst:0, vld:4'h8, last:4'h0, ret:1, rdy:4'h8, avail:1, id:3, slast:0, cnt:8, err:0};
            apply(v);
            v = '{rst:0, vld:4'h8, last:4'h0, ret:0, rdy:4'h8, avail:1, id:3, slast:0, cnt:7, err:0};
            apply(v);
            v = '{rst:1, vld:4'h9, last:4'h0, ret:0, rdy:4'h0, avail:0, id:0, slast:0, cnt:8, err:0};
            apply(v);
            v = '{rst:0, vld:4'h9, last:4'h1, ret:0, rdy:4'h1, avail:1, id:0, slast:1, cnt:7, err:0};
            apply(v);
            v = '{rst:0, vld:4'h8, last:4'h8, ret:0, rdy:4'h8, avail:1, id:3, slast:1, cnt:6, err:0};
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
